hazard_stall_ctrl: RTL

//  Pipeline stall/bubble sequencer for the 5-stage MIPS core.
//  - Detects load-use hazards between the ID and EX stages.
//  - Drives the PC/IF-ID stall and the ID-EX bubble.
//  - Raises the per-operand load_use1/load_use2 flags consumed by the EX operand-hold logic.
//  - Freezes the whole pipe while a data-memory access is outstanding.
//  - Counts stall cycles.

---
 rtl/hazard_stall_ctrl_pkg.sv | 9 +
 rtl/hazard_stall_ctrl_if.sv | 31 +++
 rtl/hazard_stall_ctrl_sat_counter.sv | 15 +
 rtl/hazard_stall_ctrl.sv | 68 ++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared constants for the load-use / memory-wait stall sequencer
package hazard_stall_ctrl_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU       = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    // sll $0,$0,0 is what ID/EX receives when a bubble is inserted
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-side hazard inputs and stall/freeze controls
interface hazard_stall_ctrl_if #(
    parameter int REG_AW = hazard_stall_ctrl_pkg::REG_AW,
    parameter int PERF_W = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              mem_req;
    logic              mem_ready;
    logic              exc_flush;
    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_bubble;
    logic              pipe_freeze;
    logic              load_use1;
    logic              load_use2;
    logic              mem_timeout;
    logic [PERF_W-1:0] stall_cycles;
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read, mem_req, mem_ready, exc_flush,
        output pc_stall, ifid_stall, idex_bubble, pipe_freeze, load_use1, load_use2, mem_timeout, stall_cycles
    );
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read, mem_req, mem_ready, exc_flush,
        input  pc_stall, ifid_stall, idex_bubble, pipe_freeze, load_use1, load_use2, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter: synchronous-clear up counter that sticks at all-ones
module sat_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [PERF_W-1:0] o_cnt
);
    logic [PERF_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        r_cnt <= i_clr ? '0 : (i_inc & ~&r_cnt) ? r_cnt + 1'b1 : r_cnt;
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble, memory-wait freeze and flush sequencer with stall counter
module hazard_stall_ctrl #(
    parameter int REG_AW   = hazard_stall_ctrl_pkg::REG_AW,
    parameter int PERF_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_ctrl_if.slave bus
);
    import hazard_stall_ctrl_pkg::*;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);
    logic [1:0]        r_state;
    logic [1:0]        w_state_n;
    logic [WW-1:0]     r_wait;
    logic [WW-1:0]     w_wait_n;
    logic              r_timeout;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic              w_hz1;
    logic              w_hz2;
    logic              w_mwait;
    logic              w_active;
    logic              w_freeze;
    logic              w_lu;
    logic              w_stall;
    // every frozen cycle counts as a wait cycle, including the one that enters MEM_WAIT
    always_comb begin
        w_rs      = bus.id_rs;
        w_rt      = bus.id_rt;
        w_rd      = bus.ex_rd;
        w_hz1     = bus.ex_mem_read & (|w_rd) & bus.id_use_rs & (w_rs == w_rd);
        w_hz2     = bus.ex_mem_read & (|w_rd) & bus.id_use_rt & (w_rt == w_rd);
        w_mwait   = bus.mem_req & ~bus.mem_ready;
        w_active  = ~rst & ~bus.exc_flush;
        w_freeze  = w_active & ((r_state == ST_MEM_WAIT) ? ~bus.mem_ready : w_mwait);
        w_lu      = w_active & ~w_freeze & (r_state == ST_RUN) & (w_hz1 | w_hz2);
        w_stall   = w_freeze | w_lu;
        w_state_n = w_freeze ? ST_MEM_WAIT : w_lu ? ST_LU : ST_RUN;
        w_wait_n  = ~w_freeze ? '0 : (r_wait == W_MAX) ? r_wait : r_wait + 1'b1;
    end
    assign bus.pc_stall    = w_stall;
    assign bus.ifid_stall  = w_stall;
    assign bus.idex_bubble = w_lu | (~rst & bus.exc_flush);
    assign bus.pipe_freeze = w_freeze;
    assign bus.load_use1   = w_lu & w_hz1;
    assign bus.load_use2   = w_lu & w_hz2;
    assign bus.mem_timeout = r_timeout & ~rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_wait    <= w_wait_n;
            r_timeout <= r_timeout | (w_wait_n == W_MAX);
        end
    end
    sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_stall),
        .o_cnt (bus.stall_cycles)
    );
endmodule
